// File: rtl/fetch_pkg.sv
// Shared widths, opcode encodings, sequencer states and flag layout for the fetch path.
package fetch_pkg;

    localparam int PC_W   = 9;
    localparam int INST_W = 20;
    localparam int CNT_W  = 16;
    localparam int OP_W   = 5;

    localparam logic [OP_W-1:0] OP_CMP  = 5'b00110;
    localparam logic [OP_W-1:0] OP_BE   = 5'b00111;
    localparam logic [OP_W-1:0] OP_BL   = 5'b01000;
    localparam logic [OP_W-1:0] OP_BG   = 5'b01001;
    localparam logic [OP_W-1:0] OP_BA   = 5'b01010;
    localparam logic [OP_W-1:0] OP_DONE = 5'b01110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic eq;
        logic lt;
        logic gt;
    } flags_t;

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch decision and next-pc selection for one fetched instruction.
module branch_resolve
    import fetch_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    input  flags_t          flags,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] offset,
    output logic            taken,
    output logic [PC_W-1:0] next_pc
);

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BE:   taken = flags.eq;
            OP_BL:   taken = flags.lt;
            OP_BG:   taken = flags.gt;
            OP_BA:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // Only the low PC_W offset bits matter: the add is modulo 2^PC_W.
    assign next_pc = taken ? (pc + offset) : (pc + PC_W'(1));

endmodule

// File: rtl/fetch_ctrl.sv
// Program counter / fetch sequencer with compare flags and branch resolution.
// Optional executed-instruction counter enabled by defining FETCH_CYCLE_CNT_EN.
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [PC_W-1:0]   StartAddr,
    input  logic [INST_W-1:0] Inst,
    input  logic              AluEq,
    input  logic              AluLt,
    input  logic              AluGt,
    output logic [PC_W-1:0]   Iptr,
    output logic              Run,
    output logic              Done,
    output logic              FlagEq,
    output logic              FlagLt,
    output logic              FlagGt
`ifdef FETCH_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0]  CycleCnt
`endif
);

    fetch_state_t    state, state_n;
    logic [PC_W-1:0] pc, pc_n, br_pc;
    flags_t          flags, flags_n;
    logic            taken;
    logic            start_ok;
    logic [OP_W-1:0] opcode;
    logic            unused_ok;

    assign opcode    = Inst[INST_W-1 -: OP_W];
    assign start_ok  = Start && ((state == IDLE) || (state == HALT));
    assign unused_ok = ^{Inst[INST_W-OP_W-1:PC_W], taken};

    branch_resolve u_branch_resolve (
        .opcode  (opcode),
        .flags   (flags),
        .pc      (pc),
        .offset  (Inst[PC_W-1:0]),
        .taken   (taken),
        .next_pc (br_pc)
    );

    always_comb begin
        state_n = state;
        pc_n    = pc;
        flags_n = flags;
        case (state)
            IDLE, HALT: begin
                if (start_ok) begin
                    pc_n    = StartAddr;
                    flags_n = '0;
                    state_n = RUN;
                end
            end
            RUN: begin
                pc_n = br_pc;
                if (opcode == OP_CMP) begin
                    flags_n = {AluEq, AluLt, AluGt};
                end
                if (opcode == OP_DONE) begin
                    pc_n    = pc;
                    state_n = HALT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state <= IDLE;
            pc    <= '0;
            flags <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            flags <= flags_n;
        end
    end

    assign Iptr   = pc;
    assign Run    = (state == RUN);
    assign Done   = (state == HALT);
    assign FlagEq = flags.eq;
    assign FlagLt = flags.lt;
    assign FlagGt = flags.gt;

`ifdef FETCH_CYCLE_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge Clk) begin
        if (!Reset_n || start_ok) begin
            cnt <= '0;
        end else if ((state == RUN) && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign CycleCnt = cnt;
`endif

endmodule
